// File: rtl/mc_perf_pkg.sv
// -----------------------------------------------------------------------------
// mc_perf_pkg
// Shared types and helpers for the MC AXI4 performance monitor.
//   MC_PERF_CH_STRUCT(CW, IW) : per-channel live-state record, width-generic.
//                               Packages cannot take parameters, so the layout
//                               lives in a macro and each width instantiates it.
//   t_ch_perf                 : the record at the default 64/16 widths.
//   CNT_MAX                   : all-ones at the widest supported counter width.
//   sat_add()                 : width-generic saturating add (counters <= 64 b).
// -----------------------------------------------------------------------------
`define MC_PERF_CH_STRUCT(CW, IW) struct packed { \
  logic [(CW)-1:0] ar_cnt;      \
  logic [(CW)-1:0] aw_cnt;      \
  logic [(CW)-1:0] rbeat_cnt;   \
  logic [(CW)-1:0] rlast_cnt;   \
  logic [(CW)-1:0] b_cnt;       \
  logic [(IW)-1:0] rd_infl;     \
  logic [(IW)-1:0] wr_infl;     \
  logic [(IW)-1:0] rd_peak;     \
  logic [(IW)-1:0] wr_peak;     \
  logic [(CW)-1:0] rd_infl_cyc; \
  logic [(CW)-1:0] wr_infl_cyc; \
  logic            err;         \
}

package mc_perf_pkg;

  // Widest counter the saturating helper supports.
  localparam int unsigned ACC_W = 64;
  localparam logic [ACC_W-1:0] CNT_MAX = '1;

  localparam int unsigned CNT_W_DEF  = 64;
  localparam int unsigned INFL_W_DEF = 16;

  typedef `MC_PERF_CH_STRUCT(CNT_W_DEF, INFL_W_DEF) t_ch_perf;

  // All-ones value of a w-bit counter, expressed at ACC_W bits.
  function automatic logic [ACC_W-1:0] width_max(input int unsigned w);
    return (w >= ACC_W) ? CNT_MAX : ((ACC_W'(1) << w) - ACC_W'(1));
  endfunction

  // a + b clamped to the all-ones value of a w-bit counter; never wraps.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b,
                                               input int unsigned      w);
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] max;
    max = width_max(w);
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max}) ? max : sum[ACC_W-1:0];
  endfunction

endpackage

// File: rtl/mc_perf_ch_cnt.sv
// -----------------------------------------------------------------------------
// mc_perf_ch_cnt
// Live and shadow performance state of one monitored AXI4 channel.
//   clk, rst_n        : clock, asynchronous active-low reset
//   count_en          : live state advances this cycle
//   clear             : zero live state (wins over count_en); shadow untouched
//   update            : copy live state (incl. this cycle's counting) to shadow
//   *_hs              : AR / AW / R-beat / R-last / B handshakes of this cycle
//   o_*_cnt, o_*_peak, o_*_infl_cyc : shadow values
//   o_rd_infl, o_wr_infl, o_err     : live values
// CNT_W must not exceed mc_perf_pkg::ACC_W (64).
// -----------------------------------------------------------------------------
module mc_perf_ch_cnt
  import mc_perf_pkg::*;
#(
  parameter int unsigned CNT_W  = 64,
  parameter int unsigned INFL_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              count_en,
  input  logic              clear,
  input  logic              update,
  input  logic              ar_hs,
  input  logic              aw_hs,
  input  logic              r_hs,
  input  logic              rlast_hs,
  input  logic              b_hs,
  output logic [CNT_W-1:0]  o_ar_cnt,
  output logic [CNT_W-1:0]  o_aw_cnt,
  output logic [CNT_W-1:0]  o_rbeat_cnt,
  output logic [CNT_W-1:0]  o_rlast_cnt,
  output logic [CNT_W-1:0]  o_b_cnt,
  output logic [INFL_W-1:0] o_rd_infl,
  output logic [INFL_W-1:0] o_wr_infl,
  output logic [INFL_W-1:0] o_rd_peak,
  output logic [INFL_W-1:0] o_wr_peak,
  output logic [CNT_W-1:0]  o_rd_infl_cyc,
  output logic [CNT_W-1:0]  o_wr_infl_cyc,
  output logic              o_err
);

  typedef `MC_PERF_CH_STRUCT(CNT_W, INFL_W) t_live;

  // Only what the CSR side reads back is shadowed.
  typedef struct packed {
    logic [CNT_W-1:0]  ar_cnt;
    logic [CNT_W-1:0]  aw_cnt;
    logic [CNT_W-1:0]  rbeat_cnt;
    logic [CNT_W-1:0]  rlast_cnt;
    logic [CNT_W-1:0]  b_cnt;
    logic [INFL_W-1:0] rd_peak;
    logic [INFL_W-1:0] wr_peak;
    logic [CNT_W-1:0]  rd_infl_cyc;
    logic [CNT_W-1:0]  wr_infl_cyc;
  } t_shadow;

  localparam logic [INFL_W-1:0] INFL_MAX = '1;

  t_live   live_q, live_d, live_cnt;
  t_shadow shadow_q, shadow_d;
  t_live   snap_src;
  logic [INFL_W:0] rd_step, wr_step;

  function automatic logic [CNT_W-1:0] cnt_add(input logic [CNT_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
    return CNT_W'(sat_add(ACC_W'(a), b, CNT_W));
  endfunction

  // Returns {err, next_depth}. Simultaneous issue and completion cancel out.
  function automatic logic [INFL_W:0] depth_step(input logic [INFL_W-1:0] d,
                                                 input logic              inc,
                                                 input logic              dec);
    logic [INFL_W-1:0] nxt;
    logic              err;
    nxt = d;
    err = 1'b0;
    if (inc && !dec) begin
      if (d == INFL_MAX) err = 1'b1;
      else               nxt = d + INFL_W'(1);
    end else if (dec && !inc) begin
      if (d == '0) err = 1'b1;
      else         nxt = d - INFL_W'(1);
    end
    return {err, nxt};
  endfunction

  function automatic logic [INFL_W-1:0] peak_of(input logic [INFL_W-1:0] pk,
                                                input logic [INFL_W-1:0] d);
    return (d > pk) ? d : pk;
  endfunction

  // Live state as it would be after counting this cycle.
  always_comb begin
    // NOTE: every combinational output gets a full default first so no path
    // leaves it unassigned and no latch is inferred.
    live_cnt = live_q;
    rd_step  = depth_step(live_q.rd_infl, ar_hs, rlast_hs);
    wr_step  = depth_step(live_q.wr_infl, aw_hs, b_hs);

    live_cnt.ar_cnt      = cnt_add(live_q.ar_cnt,    ACC_W'(ar_hs));
    live_cnt.aw_cnt      = cnt_add(live_q.aw_cnt,    ACC_W'(aw_hs));
    live_cnt.rbeat_cnt   = cnt_add(live_q.rbeat_cnt, ACC_W'(r_hs));
    live_cnt.rlast_cnt   = cnt_add(live_q.rlast_cnt, ACC_W'(rlast_hs));
    live_cnt.b_cnt       = cnt_add(live_q.b_cnt,     ACC_W'(b_hs));
    // Accumulators integrate the depth held during this cycle (pre-update).
    live_cnt.rd_infl_cyc = cnt_add(live_q.rd_infl_cyc, ACC_W'(live_q.rd_infl));
    live_cnt.wr_infl_cyc = cnt_add(live_q.wr_infl_cyc, ACC_W'(live_q.wr_infl));
    live_cnt.rd_infl     = rd_step[INFL_W-1:0];
    live_cnt.wr_infl     = wr_step[INFL_W-1:0];
    // Peaks track the post-update depth so they settle in the same cycle.
    live_cnt.rd_peak     = peak_of(live_q.rd_peak, rd_step[INFL_W-1:0]);
    live_cnt.wr_peak     = peak_of(live_q.wr_peak, wr_step[INFL_W-1:0]);
    live_cnt.err         = live_q.err | rd_step[INFL_W] | wr_step[INFL_W];
  end

  always_comb begin
    live_d = live_q;
    if (clear)         live_d = '0;
    else if (count_en) live_d = live_cnt;

    // A clear in the update cycle snapshots the pre-clear live value.
    snap_src = (count_en && !clear) ? live_cnt : live_q;

    shadow_d = shadow_q;
    if (update) begin
      shadow_d.ar_cnt      = snap_src.ar_cnt;
      shadow_d.aw_cnt      = snap_src.aw_cnt;
      shadow_d.rbeat_cnt   = snap_src.rbeat_cnt;
      shadow_d.rlast_cnt   = snap_src.rlast_cnt;
      shadow_d.b_cnt       = snap_src.b_cnt;
      shadow_d.rd_peak     = snap_src.rd_peak;
      shadow_d.wr_peak     = snap_src.wr_peak;
      shadow_d.rd_infl_cyc = snap_src.rd_infl_cyc;
      shadow_d.wr_infl_cyc = snap_src.wr_infl_cyc;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q   <= '0;
      shadow_q <= '0;
    end else begin
      live_q   <= live_d;
      shadow_q <= shadow_d;
    end
  end

  assign o_ar_cnt      = shadow_q.ar_cnt;
  assign o_aw_cnt      = shadow_q.aw_cnt;
  assign o_rbeat_cnt   = shadow_q.rbeat_cnt;
  assign o_rlast_cnt   = shadow_q.rlast_cnt;
  assign o_b_cnt       = shadow_q.b_cnt;
  assign o_rd_peak     = shadow_q.rd_peak;
  assign o_wr_peak     = shadow_q.wr_peak;
  assign o_rd_infl_cyc = shadow_q.rd_infl_cyc;
  assign o_wr_infl_cyc = shadow_q.wr_infl_cyc;
  assign o_rd_infl     = live_q.rd_infl;
  assign o_wr_infl     = live_q.wr_infl;
  assign o_err         = live_q.err;

endmodule

// File: rtl/mc_axi_perf_monitor.sv
// -----------------------------------------------------------------------------
// mc_axi_perf_monitor
// Passive per-channel AXI4 performance monitor for the MC emulation path.
// Only taps valid/ready (and rlast); it never drives the bus.
//   axi4_mm_clk, axi4_mm_rst_n : clock, asynchronous active-low reset
//   i_enable    : count when 1, hold live state when 0
//   i_clear     : zero live counters/depths/peaks/err and release freeze
//   i_update    : snapshot live counters into the shadow registers
//   i_end_proc  : freeze counting from the next cycle until i_clear
//   i_ar*/i_aw*/i_r*/i_b* : per-channel taps, bit c = channel c
//   o_*_cnt, o_*_peak, o_*_infl_cyc : shadow values, [channel][width]
//   o_rd_infl, o_wr_infl : live in-flight depth
//   o_err       : sticky per-channel protocol/overflow flag
//   o_frozen    : freeze state
// -----------------------------------------------------------------------------
module mc_axi_perf_monitor
  import mc_perf_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 64,
  parameter int unsigned INFL_W = 16
) (
  input  logic                          axi4_mm_clk,
  input  logic                          axi4_mm_rst_n,
  input  logic                          i_enable,
  input  logic                          i_clear,
  input  logic                          i_update,
  input  logic                          i_end_proc,
  input  logic [NUM_CH-1:0]             i_arvalid,
  input  logic [NUM_CH-1:0]             i_arready,
  input  logic [NUM_CH-1:0]             i_awvalid,
  input  logic [NUM_CH-1:0]             i_awready,
  input  logic [NUM_CH-1:0]             i_rvalid,
  input  logic [NUM_CH-1:0]             i_rready,
  input  logic [NUM_CH-1:0]             i_rlast,
  input  logic [NUM_CH-1:0]             i_bvalid,
  input  logic [NUM_CH-1:0]             i_bready,
  output logic [NUM_CH-1:0][CNT_W-1:0]  o_ar_cnt,
  output logic [NUM_CH-1:0][CNT_W-1:0]  o_aw_cnt,
  output logic [NUM_CH-1:0][CNT_W-1:0]  o_rbeat_cnt,
  output logic [NUM_CH-1:0][CNT_W-1:0]  o_rlast_cnt,
  output logic [NUM_CH-1:0][CNT_W-1:0]  o_b_cnt,
  output logic [NUM_CH-1:0][INFL_W-1:0] o_rd_infl,
  output logic [NUM_CH-1:0][INFL_W-1:0] o_wr_infl,
  output logic [NUM_CH-1:0][INFL_W-1:0] o_rd_peak,
  output logic [NUM_CH-1:0][INFL_W-1:0] o_wr_peak,
  output logic [NUM_CH-1:0][CNT_W-1:0]  o_rd_infl_cyc,
  output logic [NUM_CH-1:0][CNT_W-1:0]  o_wr_infl_cyc,
  output logic [NUM_CH-1:0]             o_err,
  output logic                          o_frozen
);

  logic frozen_q, frozen_d;
  logic count_en;

  // Freeze takes effect next cycle, so the i_end_proc cycle itself still counts.
  // A clear in the same cycle as i_end_proc leaves the monitor unfrozen.
  always_comb begin
    frozen_d = frozen_q;
    if (i_clear)         frozen_d = 1'b0;
    else if (i_end_proc) frozen_d = 1'b1;
  end

  always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
    if (!axi4_mm_rst_n) frozen_q <= 1'b0;
    else                frozen_q <= frozen_d;
  end

  assign count_en = i_enable & ~frozen_q;
  assign o_frozen = frozen_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    mc_perf_ch_cnt #(
      .CNT_W  (CNT_W),
      .INFL_W (INFL_W)
    ) u_ch (
      .clk           (axi4_mm_clk),
      .rst_n         (axi4_mm_rst_n),
      .count_en      (count_en),
      .clear         (i_clear),
      .update        (i_update),
      .ar_hs         (i_arvalid[g] & i_arready[g]),
      .aw_hs         (i_awvalid[g] & i_awready[g]),
      .r_hs          (i_rvalid[g] & i_rready[g]),
      .rlast_hs      (i_rvalid[g] & i_rready[g] & i_rlast[g]),
      .b_hs          (i_bvalid[g] & i_bready[g]),
      .o_ar_cnt      (o_ar_cnt[g]),
      .o_aw_cnt      (o_aw_cnt[g]),
      .o_rbeat_cnt   (o_rbeat_cnt[g]),
      .o_rlast_cnt   (o_rlast_cnt[g]),
      .o_b_cnt       (o_b_cnt[g]),
      .o_rd_infl     (o_rd_infl[g]),
      .o_wr_infl     (o_wr_infl[g]),
      .o_rd_peak     (o_rd_peak[g]),
      .o_wr_peak     (o_wr_peak[g]),
      .o_rd_infl_cyc (o_rd_infl_cyc[g]),
      .o_wr_infl_cyc (o_wr_infl_cyc[g]),
      .o_err         (o_err[g])
    );
  end

endmodule

// File: tb/tb_mc_axi_perf_monitor.sv
// -----------------------------------------------------------------------------
// tb_mc_axi_perf_monitor
// Drives a 64-bit-counter and an 8-bit-counter monitor from the same taps and
// compares both against a transaction-level model of the counting rules.
// -----------------------------------------------------------------------------
module tb_mc_axi_perf_monitor;

  localparam int NCH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic en, clr, upd, endp;
  logic [NCH-1:0] arv, arr, awv, awr, rv, rr, rl, bv, br;

  logic [NCH-1:0][63:0] w64_ar, w64_aw, w64_rb, w64_rl, w64_b, w64_rdcyc, w64_wrcyc;
  logic [NCH-1:0][15:0] w64_rdinfl, w64_wrinfl, w64_rdpk, w64_wrpk;
  logic [NCH-1:0]       w64_err;
  logic                 w64_frozen;

  logic [NCH-1:0][7:0]  w8_ar, w8_aw, w8_rb, w8_rl, w8_b, w8_rdcyc, w8_wrcyc;
  logic [NCH-1:0][15:0] w8_rdinfl, w8_wrinfl, w8_rdpk, w8_wrpk;
  logic [NCH-1:0]       w8_err;
  logic                 w8_frozen;

  mc_axi_perf_monitor #(.NUM_CH(NCH), .CNT_W(64), .INFL_W(16)) dut (
    .axi4_mm_clk(clk), .axi4_mm_rst_n(rst_n),
    .i_enable(en), .i_clear(clr), .i_update(upd), .i_end_proc(endp),
    .i_arvalid(arv), .i_arready(arr), .i_awvalid(awv), .i_awready(awr),
    .i_rvalid(rv), .i_rready(rr), .i_rlast(rl), .i_bvalid(bv), .i_bready(br),
    .o_ar_cnt(w64_ar), .o_aw_cnt(w64_aw), .o_rbeat_cnt(w64_rb), .o_rlast_cnt(w64_rl),
    .o_b_cnt(w64_b), .o_rd_infl(w64_rdinfl), .o_wr_infl(w64_wrinfl),
    .o_rd_peak(w64_rdpk), .o_wr_peak(w64_wrpk),
    .o_rd_infl_cyc(w64_rdcyc), .o_wr_infl_cyc(w64_wrcyc),
    .o_err(w64_err), .o_frozen(w64_frozen)
  );

  mc_axi_perf_monitor #(.NUM_CH(NCH), .CNT_W(8), .INFL_W(16)) dut8 (
    .axi4_mm_clk(clk), .axi4_mm_rst_n(rst_n),
    .i_enable(en), .i_clear(clr), .i_update(upd), .i_end_proc(endp),
    .i_arvalid(arv), .i_arready(arr), .i_awvalid(awv), .i_awready(awr),
    .i_rvalid(rv), .i_rready(rr), .i_rlast(rl), .i_bvalid(bv), .i_bready(br),
    .o_ar_cnt(w8_ar), .o_aw_cnt(w8_aw), .o_rbeat_cnt(w8_rb), .o_rlast_cnt(w8_rl),
    .o_b_cnt(w8_b), .o_rd_infl(w8_rdinfl), .o_wr_infl(w8_wrinfl),
    .o_rd_peak(w8_rdpk), .o_wr_peak(w8_wrpk),
    .o_rd_infl_cyc(w8_rdcyc), .o_wr_infl_cyc(w8_wrcyc),
    .o_err(w8_err), .o_frozen(w8_frozen)
  );

  // ---------------- reference model: unbounded true counts ----------------
  typedef struct {
    longint unsigned ar, aw, rb, rl, b, rdcyc, wrcyc;
    int unsigned     rd, wr, rdpk, wrpk;
    bit              err;
  } ch_t;

  ch_t live [NCH];
  ch_t shad [NCH];
  bit  m_frozen;

  int n_checks = 0;
  int n_fail   = 0;

  // Saturating counters only ever grow, so the w-bit view is min(true, max).
  function automatic logic [63:0] satw(input longint unsigned v, input int w);
    longint unsigned mx;
    if (w >= 64) return v;
    mx = (64'd1 << w) - 64'd1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      live[c] = '{default: 0};
      shad[c] = '{default: 0};
    end
    m_frozen = 1'b0;
  endtask

  task automatic model_step();
    bit active;
    active = en && !m_frozen;
    for (int c = 0; c < NCH; c++) begin
      ch_t nxt;
      bit ar_h, aw_h, r_h, rl_h, b_h;
      ar_h = arv[c] && arr[c];
      aw_h = awv[c] && awr[c];
      r_h  = rv[c] && rr[c];
      rl_h = r_h && rl[c];
      b_h  = bv[c] && br[c];
      nxt = live[c];
      nxt.ar += 64'(ar_h);
      nxt.aw += 64'(aw_h);
      nxt.rb += 64'(r_h);
      nxt.rl += 64'(rl_h);
      nxt.b  += 64'(b_h);
      nxt.rdcyc += 64'(live[c].rd);
      nxt.wrcyc += 64'(live[c].wr);
      if (ar_h && !rl_h) begin
        if (nxt.rd == 65535) nxt.err = 1'b1; else nxt.rd++;
      end else if (rl_h && !ar_h) begin
        if (nxt.rd == 0) nxt.err = 1'b1; else nxt.rd--;
      end
      if (aw_h && !b_h) begin
        if (nxt.wr == 65535) nxt.err = 1'b1; else nxt.wr++;
      end else if (b_h && !aw_h) begin
        if (nxt.wr == 0) nxt.err = 1'b1; else nxt.wr--;
      end
      if (nxt.rd > nxt.rdpk) nxt.rdpk = nxt.rd;
      if (nxt.wr > nxt.wrpk) nxt.wrpk = nxt.wr;
      if (upd) shad[c] = (active && !clr) ? nxt : live[c];
      if (clr)         live[c] = '{default: 0};
      else if (active) live[c] = nxt;
    end
    if (clr)       m_frozen = 1'b0;
    else if (endp) m_frozen = 1'b1;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int c = 0; c < NCH; c++) begin
      string t;
      t = $sformatf("%s ch%0d", tag, c);
      chk({t, " ar64"},    w64_ar[c],    satw(shad[c].ar, 64));
      chk({t, " aw64"},    w64_aw[c],    satw(shad[c].aw, 64));
      chk({t, " rb64"},    w64_rb[c],    satw(shad[c].rb, 64));
      chk({t, " rl64"},    w64_rl[c],    satw(shad[c].rl, 64));
      chk({t, " b64"},     w64_b[c],     satw(shad[c].b, 64));
      chk({t, " rdcyc64"}, w64_rdcyc[c], satw(shad[c].rdcyc, 64));
      chk({t, " wrcyc64"}, w64_wrcyc[c], satw(shad[c].wrcyc, 64));
      chk({t, " ar8"},     64'(w8_ar[c]),    satw(shad[c].ar, 8));
      chk({t, " aw8"},     64'(w8_aw[c]),    satw(shad[c].aw, 8));
      chk({t, " rb8"},     64'(w8_rb[c]),    satw(shad[c].rb, 8));
      chk({t, " rl8"},     64'(w8_rl[c]),    satw(shad[c].rl, 8));
      chk({t, " b8"},      64'(w8_b[c]),     satw(shad[c].b, 8));
      chk({t, " rdcyc8"},  64'(w8_rdcyc[c]), satw(shad[c].rdcyc, 8));
      chk({t, " wrcyc8"},  64'(w8_wrcyc[c]), satw(shad[c].wrcyc, 8));
      chk({t, " rdinfl"},  64'(w64_rdinfl[c]), 64'(live[c].rd));
      chk({t, " wrinfl"},  64'(w64_wrinfl[c]), 64'(live[c].wr));
      chk({t, " rdpk"},    64'(w64_rdpk[c]),   64'(shad[c].rdpk));
      chk({t, " wrpk"},    64'(w64_wrpk[c]),   64'(shad[c].wrpk));
      chk({t, " err"},     64'(w64_err[c]),    64'(live[c].err));
      chk({t, " rdinfl8"}, 64'(w8_rdinfl[c]),  64'(live[c].rd));
      chk({t, " wrinfl8"}, 64'(w8_wrinfl[c]),  64'(live[c].wr));
      chk({t, " rdpk8"},   64'(w8_rdpk[c]),    64'(shad[c].rdpk));
      chk({t, " wrpk8"},   64'(w8_wrpk[c]),    64'(shad[c].wrpk));
      chk({t, " err8"},    64'(w8_err[c]),     64'(live[c].err));
    end
    chk({tag, " frozen"},  64'(w64_frozen), 64'(m_frozen));
    chk({tag, " frozen8"}, 64'(w8_frozen),  64'(m_frozen));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle_in();
    {arv, arr, awv, awr, rv, rr, rl, bv, br} = '0;
    clr  = 1'b0;
    upd  = 1'b0;
    endp = 1'b0;
  endtask

  // Inputs change at negedge; the edge samples them, the model follows.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic pulse_update();
    idle_in(); upd = 1'b1; step(); idle_in();
  endtask

  task automatic pulse_clear();
    idle_in(); clr = 1'b1; step(); idle_in();
  endtask

  initial begin
    idle_in();
    en = 1'b1;
    model_reset();

    // Reset state
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single read: AR in cycle 0, four R beats, last on beat 4
    arv[0] = 1'b1; arr[0] = 1'b1; step(); idle_in();
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("single_rd infl cyc%0d", i), 64'(w64_rdinfl[0]), 64'd1);
      rv[0] = 1'b1; rr[0] = 1'b1; rl[0] = (i == 4);
      step();
    end
    idle_in();
    chk("single_rd infl after", 64'(w64_rdinfl[0]), 64'd0);
    pulse_update();
    chk("single_rd ar",    w64_ar[0],    64'd1);
    chk("single_rd rbeat", w64_rb[0],    64'd4);
    chk("single_rd rlast", w64_rl[0],    64'd1);
    chk("single_rd cyc",   w64_rdcyc[0], 64'd4);
    check_all("single_rd");

    // Depth 3 then simultaneous AR and R-last
    pulse_clear();
    for (int i = 0; i < 3; i++) begin
      arv[0] = 1'b1; arr[0] = 1'b1; step();
    end
    idle_in();
    arv[0] = 1'b1; arr[0] = 1'b1; rv[0] = 1'b1; rr[0] = 1'b1; rl[0] = 1'b1;
    step();
    pulse_update();
    chk("simul infl", 64'(w64_rdinfl[0]), 64'd3);
    chk("simul peak", 64'(w64_rdpk[0]),   64'd3);
    chk("simul err",  64'(w64_err[0]),    64'd0);
    check_all("simul");

    // B with zero writes outstanding: sticky error until clear
    bv[0] = 1'b1; br[0] = 1'b1; step(); idle_in();
    chk("b_underflow err",   64'(w64_err[0]),    64'd1);
    chk("b_underflow depth", 64'(w64_wrinfl[0]), 64'd0);
    chk("b_underflow ch1",   64'(w64_err[1]),    64'd0);
    step(); step(); step();
    chk("b_underflow sticky", 64'(w64_err[0]), 64'd1);
    pulse_clear();
    chk("b_underflow cleared", 64'(w64_err[0]), 64'd0);
    check_all("b_underflow");

    // Five outstanding writes on ch1, ch0 idle
    for (int i = 0; i < 5; i++) begin
      awv[1] = 1'b1; awr[1] = 1'b1; step();
    end
    pulse_update();
    chk("wr5 peak ch1",  64'(w64_wrpk[1]), 64'd5);
    chk("wr5 ch0 ar",    w64_ar[0],        64'd0);
    chk("wr5 ch0 wrpk",  64'(w64_wrpk[0]), 64'd0);
    chk("wr5 ch0 rdcyc", w64_rdcyc[0],     64'd0);
    check_all("wr5");

    // End of processing: the i_end_proc cycle counts, later handshakes do not
    pulse_clear();
    endp = 1'b1; arv[0] = 1'b1; arr[0] = 1'b1; step(); idle_in();
    chk("freeze frozen", 64'(w64_frozen), 64'd1);
    for (int i = 0; i < 10; i++) begin
      arv = '1; arr = '1; awv = '1; awr = '1; rv = '1; rr = '1; rl = '1;
      bv = '1; br = '1;
      step();
    end
    pulse_update();
    chk("freeze ar",     w64_ar[0],              64'd1);
    chk("freeze rbeat",  w64_rb[0],              64'd0);
    chk("freeze infl",   64'(w64_rdinfl[0]),     64'd1);
    check_all("freeze");
    pulse_clear();
    chk("unfreeze frozen", 64'(w64_frozen),   64'd0);
    chk("unfreeze infl",   64'(w64_rdinfl[0]), 64'd0);
    chk("unfreeze shadow", w64_ar[0],         64'd1);
    check_all("unfreeze");

    // Clear and update together: shadow takes the pre-clear value
    for (int i = 0; i < 3; i++) begin
      arv[1] = 1'b1; arr[1] = 1'b1; step();
    end
    idle_in(); clr = 1'b1; upd = 1'b1; step(); idle_in();
    chk("clr_upd ar ch1",   w64_ar[1],              64'd3);
    chk("clr_upd infl ch1", 64'(w64_rdinfl[1]),     64'd0);
    check_all("clr_upd");

    // 300 AR handshakes: 8-bit counters pin at 255
    for (int i = 0; i < 300; i++) begin
      arv[0] = 1'b1; arr[0] = 1'b1; step();
    end
    pulse_update();
    chk("sat ar8",    64'(w8_ar[0]),    64'd255);
    chk("sat ar64",   w64_ar[0],        64'd300);
    chk("sat cyc8",   64'(w8_rdcyc[0]), 64'd255);
    chk("sat cyc64",  w64_rdcyc[0],     64'd45150);
    check_all("sat");

    // Asynchronous reset in the middle of a burst
    for (int i = 0; i < 5; i++) begin
      arv[0] = 1'b1; arr[0] = 1'b1; step();
    end
    #2 rst_n = 1'b0;
    #1 model_reset();
    chk("async_rst ar64", w64_ar[0],          64'd0);
    chk("async_rst ar8",  64'(w8_ar[0]),      64'd0);
    chk("async_rst infl", 64'(w64_rdinfl[0]), 64'd0);
    check_all("async_rst");
    idle_in();
    @(negedge clk);
    rst_n = 1'b1;
    pulse_update();
    check_all("post_rst");

    // Randomised traffic on both channels
    for (int i = 0; i < 400; i++) begin
      arv = NCH'($urandom); arr = NCH'($urandom);
      awv = NCH'($urandom); awr = NCH'($urandom);
      rv  = NCH'($urandom); rr  = NCH'($urandom); rl = NCH'($urandom);
      bv  = NCH'($urandom); br  = NCH'($urandom);
      en   = ($urandom_range(0, 9) != 0);
      upd  = ($urandom_range(0, 5) == 0);
      clr  = ($urandom_range(0, 59) == 0);
      endp = ($urandom_range(0, 79) == 0);
      step();
      if (i % 4 == 3) check_all($sformatf("rand%0d", i));
    end
    idle_in();
    en = 1'b1;
    pulse_update();
    check_all("rand_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
